// File: rtl/iq_demod_accum.sv
// ---------------------------------------------------------------------------
// iq_demod_accum
//   Consumer side of the I/Q oscillator. Each accepted ADC sample is mixed with
//   the oscillator's in-phase and quadrature references. The products are summed
//   over a window of 2**WIN_BITS samples, and the signed I and Q window sums are
//   emitted together.
//
//   The oscillator is advanced with a one-cycle osc_next pulse. It takes two
//   rising edges to update its outputs, so a three-state pacing FSM allows at
//   most one accept every three cycles. The references are therefore always
//   settled when they are sampled.
//
//   Pipeline for a sample accepted at edge E:
//     E    : sample and references registered
//     E+1  : signed products registered
//     E+2  : products added to the accumulators; on the last sample of the
//            window the sums are published and out_valid pulses
//     E+3  : (IQ_DEMOD_MAG_EN only) out_mag computed; outputs and out_valid
//            move here together
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        ADC sample valid
//   in_sample  in   DW       signed ADC sample
//   in_ready   out  1        sample can be accepted this cycle (combinational)
//   osc_next   out  1        oscillator advance pulse, high in the accept cycle
//   ref_i      in   DW       signed in-phase reference
//   ref_q      in   DW       signed quadrature reference
//   out_valid  out  1        one-cycle pulse: window sums valid
//   out_i      out  ACC_W    signed I window sum, held until the next window
//   out_q      out  ACC_W    signed Q window sum, held until the next window
//   out_mag    out  2*DW+1   hi_i^2 + hi_q^2 of the top DW bits of out_i/out_q
//                            (present only when IQ_DEMOD_MAG_EN is defined)
//
// Configuration macro: IQ_DEMOD_MAG_EN
// ---------------------------------------------------------------------------
module iq_demod_accum #(
    parameter int unsigned DW       = 16,
    parameter int unsigned WIN_BITS = 10,
    parameter int unsigned ACC_W    = 42
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_sample,
    output logic             in_ready,
    output logic             osc_next,
    input  logic [DW-1:0]    ref_i,
    input  logic [DW-1:0]    ref_q,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_i,
    output logic [ACC_W-1:0] out_q
`ifdef IQ_DEMOD_MAG_EN
    ,
    output logic [2*DW:0]    out_mag
`endif
);

    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned EXT_W = ACC_W - PW;

    localparam logic [WIN_BITS-1:0] CNT_LAST = '1;

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_WAIT1 = 2'd1;
    localparam logic [1:0] ST_WAIT2 = 2'd2;

    // The accumulator must hold N full-scale products without wrapping.
    if (ACC_W < 2 * DW + WIN_BITS) begin : g_width_check
        $error("iq_demod_accum: ACC_W must be >= 2*DW+WIN_BITS");
    end

    // ------------------------------------------------------------------
    // Pacing FSM
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic       accept;

    assign in_ready = (state_q == ST_READY) && !rst;
    assign accept   = in_valid && in_ready;
    assign osc_next = accept;

    // Next state: one accept, then two dead cycles while the oscillator settles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY: if (accept) state_d = ST_WAIT1;
            ST_WAIT1: state_d = ST_WAIT2;
            ST_WAIT2: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic signed [DW-1:0]    smp_q, smp_d;
    logic signed [DW-1:0]    ri_q, ri_d;
    logic signed [DW-1:0]    rq_q, rq_d;
    logic                    v0_q, v0_d;

    logic signed [PW-1:0]    prod_i_q, prod_i_d;
    logic signed [PW-1:0]    prod_q_q, prod_q_d;
    logic                    v1_q, v1_d;

    logic [ACC_W-1:0]        acc_i_q, acc_i_d;
    logic [ACC_W-1:0]        acc_q_q, acc_q_d;
    logic [WIN_BITS-1:0]     cnt_q, cnt_d;

    logic [ACC_W-1:0]        win_i_q, win_i_d;
    logic [ACC_W-1:0]        win_q_q, win_q_d;
    logic                    win_v_q, win_v_d;

    logic [ACC_W-1:0]        ext_i, ext_q;
    logic [ACC_W-1:0]        sum_i, sum_q;

    // Sign-extend the registered products to accumulator width.
    assign ext_i = {{EXT_W{prod_i_q[PW-1]}}, prod_i_q};
    assign ext_q = {{EXT_W{prod_q_q[PW-1]}}, prod_q_q};
    assign sum_i = acc_i_q + ext_i;
    assign sum_q = acc_q_q + ext_q;

    // Capture, multiply, accumulate; the window sum includes the last product.
    always_comb begin
        smp_d    = smp_q;
        ri_d     = ri_q;
        rq_d     = rq_q;
        v0_d     = accept;
        prod_i_d = prod_i_q;
        prod_q_d = prod_q_q;
        v1_d     = v0_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        cnt_d    = cnt_q;
        win_i_d  = win_i_q;
        win_q_d  = win_q_q;
        win_v_d  = 1'b0;

        if (accept) begin
            smp_d = in_sample;
            ri_d  = ref_i;
            rq_d  = ref_q;
        end

        if (v0_q) begin
            prod_i_d = PW'(smp_q) * PW'(ri_q);
            prod_q_d = PW'(smp_q) * PW'(rq_q);
        end

        if (v1_q) begin
            cnt_d = cnt_q + WIN_BITS'(1);
            if (cnt_q == CNT_LAST) begin
                win_i_d = sum_i;
                win_q_d = sum_q;
                win_v_d = 1'b1;
                acc_i_d = '0;
                acc_q_d = '0;
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
            end
        end
    end

    // State and datapath flops; reset discards any partial window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_READY;
            smp_q    <= '0;
            ri_q     <= '0;
            rq_q     <= '0;
            v0_q     <= 1'b0;
            prod_i_q <= '0;
            prod_q_q <= '0;
            v1_q     <= 1'b0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            cnt_q    <= '0;
            win_i_q  <= '0;
            win_q_q  <= '0;
            win_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            smp_q    <= smp_d;
            ri_q     <= ri_d;
            rq_q     <= rq_d;
            v0_q     <= v0_d;
            prod_i_q <= prod_i_d;
            prod_q_q <= prod_q_d;
            v1_q     <= v1_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            cnt_q    <= cnt_d;
            win_i_q  <= win_i_d;
            win_q_q  <= win_q_d;
            win_v_q  <= win_v_d;
        end
    end

`ifdef IQ_DEMOD_MAG_EN
    // ------------------------------------------------------------------
    // Magnitude stage: sums and magnitude are published together.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] hi_i, hi_q;
    logic signed [PW-1:0] sq_i, sq_q;

    logic [ACC_W-1:0]     out_i_q, out_i_d;
    logic [ACC_W-1:0]     out_q_q, out_q_d;
    logic [2*DW:0]        out_mag_q, out_mag_d;
    logic                 out_valid_q, out_valid_d;

    assign hi_i = win_i_q[ACC_W-1 -: DW];
    assign hi_q = win_q_q[ACC_W-1 -: DW];
    assign sq_i = PW'(hi_i) * PW'(hi_i);
    assign sq_q = PW'(hi_q) * PW'(hi_q);

    // Squares are non-negative, so their sum fits in PW+1 unsigned bits.
    always_comb begin
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_mag_d   = out_mag_q;
        out_valid_d = win_v_q;
        if (win_v_q) begin
            out_i_d   = win_i_q;
            out_q_d   = win_q_q;
            out_mag_d = {1'b0, sq_i} + {1'b0, sq_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_mag_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_mag_q   <= out_mag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_mag   = out_mag_q;
    assign out_valid = out_valid_q;
`else
    assign out_i     = win_i_q;
    assign out_q     = win_q_q;
    assign out_valid = win_v_q;
`endif

endmodule
